id_ex_stage_reg: RTL

- ID/EX pipeline register of the five-stage MIPS CPU, with integrated load-use hazard detection.
- Sits directly upstream of the forwarding unit and the EX stage. It supplies ID_EX_RegisterRs/Rt/Rd, ID_EX_MemWrite, ID_EX_MemRead and ID_EX_RegWrite to forwarding and ALU muxing.
- Inserts a one-cycle bubble on lw-use hazards, because forwarding cannot cover these.
- Handles branch flush and a global hold from the memory stage.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage_reg.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and bubble constant
// used by the ID/EX, EX/MEM and MEM/WB registers.
package pipe_pkg;

    localparam int ALUOP_W = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read
// by the instruction currently in ID.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = (ex_rt == id_rs);
        rt_hit   = id_uses_rt && (ex_rt == id_rt);
        load_use = ex_valid && ex_mem_read &&
                   (ex_rt != REG_ZERO) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// memory-stage hold and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Hold,
    input  logic               Flush,
    input  logic [4:0]         IF_ID_RegisterRs,
    input  logic [4:0]         IF_ID_RegisterRt,
    input  logic [4:0]         IF_ID_RegisterRd,
    input  logic               ID_UsesRt,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [DATA_W-1:0]  ID_PC4,
    output logic               PCWrite,
    output logic               IF_ID_Write,
    output logic               ID_EX_Valid,
    output logic [4:0]         ID_EX_RegisterRs,
    output logic [4:0]         ID_EX_RegisterRt,
    output logic [4:0]         ID_EX_RegisterRd,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemtoReg,
    output logic               ID_EX_ALUSrc,
    output logic               ID_EX_RegDst,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [DATA_W-1:0]  ID_EX_ReadData1,
    output logic [DATA_W-1:0]  ID_EX_ReadData2,
    output logic [DATA_W-1:0]  ID_EX_Imm,
    output logic [DATA_W-1:0]  ID_EX_PC4,
    output logic [CNT_W-1:0]   StallCount
);

    import pipe_pkg::*;

    logic               valid_q, valid_d;
    logic [4:0]         rs_q, rs_d;
    logic [4:0]         rt_q, rt_d;
    logic [4:0]         rd_q, rd_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
    logic [DATA_W-1:0]  rd1_q, rd1_d;
    logic [DATA_W-1:0]  rd2_q, rd2_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  pc4_q, pc4_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_use;
    logic               bubble;
    ctrl_t              id_ctrl;

    load_use_detect u_lud (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_rs       (IF_ID_RegisterRs),
        .id_rt       (IF_ID_RegisterRt),
        .id_uses_rt  (ID_UsesRt),
        .load_use    (load_use)
    );

    always_comb begin
        id_ctrl.reg_write  = ID_RegWrite;
        id_ctrl.mem_read   = ID_MemRead;
        id_ctrl.mem_write  = ID_MemWrite;
        id_ctrl.mem_to_reg = ID_MemtoReg;
        id_ctrl.alu_src    = ID_ALUSrc;
        id_ctrl.reg_dst    = ID_RegDst;
    end

    // Flush beats hold beats load-use; only a real load-use bubble counts.
    always_comb begin
        valid_d  = valid_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        ctrl_d   = ctrl_q;
        alu_op_d = alu_op_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        cnt_d    = cnt_q;
        bubble   = 1'b0;
        if (Flush) begin
            bubble = 1'b1;
        end else if (Hold) begin
            bubble = 1'b0;
        end else if (load_use) begin
            bubble = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            valid_d  = 1'b1;
            rs_d     = IF_ID_RegisterRs;
            rt_d     = IF_ID_RegisterRt;
            rd_d     = IF_ID_RegisterRd;
            ctrl_d   = id_ctrl;
            alu_op_d = ID_ALUOp;
            rd1_d    = ID_ReadData1;
            rd2_d    = ID_ReadData2;
            imm_d    = ID_Imm;
            pc4_d    = ID_PC4;
        end
        if (bubble) begin
            valid_d  = 1'b0;
            rs_d     = REG_ZERO;
            rt_d     = REG_ZERO;
            rd_d     = REG_ZERO;
            ctrl_d   = BUBBLE;
            alu_op_d = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            pc4_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            rs_q     <= REG_ZERO;
            rt_q     <= REG_ZERO;
            rd_q     <= REG_ZERO;
            ctrl_q   <= BUBBLE;
            alu_op_q <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        PCWrite          = !(load_use || Hold);
        IF_ID_Write      = !(load_use || Hold);
        ID_EX_Valid      = valid_q;
        ID_EX_RegisterRs = rs_q;
        ID_EX_RegisterRt = rt_q;
        ID_EX_RegisterRd = rd_q;
        ID_EX_RegWrite   = ctrl_q.reg_write;
        ID_EX_MemRead    = ctrl_q.mem_read;
        ID_EX_MemWrite   = ctrl_q.mem_write;
        ID_EX_MemtoReg   = ctrl_q.mem_to_reg;
        ID_EX_ALUSrc     = ctrl_q.alu_src;
        ID_EX_RegDst     = ctrl_q.reg_dst;
        ID_EX_ALUOp      = alu_op_q;
        ID_EX_ReadData1  = rd1_q;
        ID_EX_ReadData2  = rd2_q;
        ID_EX_Imm        = imm_q;
        ID_EX_PC4        = pc4_q;
        StallCount       = cnt_q;
    end

endmodule
